// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and drain FSM encoding
// for the UART receive buffer.
package uart_rx_fifo_pkg;

  localparam logic [15:0] EMPTY_WORD = 16'h8000;
  localparam int EMPTY_BIT = 15;
  localparam int OVERRUN_BIT = 14;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    SETTLE
  } drain_state_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side and CPU-side signals of
// the UART receive buffer.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic [15:0] rx_word;
  logic        rx_clear;
  logic        load;
  logic [15:0] out;
  logic [AW:0] count;

  modport slave (
    input  rx_word,
    input  load,
    output rx_clear,
    output out,
    output count
  );

  modport master (
    output rx_word,
    output load,
    input  rx_clear,
    input  out,
    input  count
  );
endinterface

// File: rtl/uart_byte_fifo.sv
// DEPTH x 8 FIFO with separate occupancy
// counter; push while full needs a pop.
module uart_byte_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_push,
  input  logic [7:0]  i_data,
  input  logic        i_pop,
  output logic        o_full,
  output logic        o_empty,
  output logic [7:0]  o_head,
  output logic [AW:0] o_count
);
  localparam logic [AW:0] FULL_CNT =
    (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push &
    (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push)
      r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)
        r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push)
        r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer. The rx_clear pulse aborts any reception in
// progress; senders must idle at least one bit time after each stop bit.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic reset,
  uart_rx_fifo_if.slave bus
);
  drain_state_t r_state;
  drain_state_t w_state_nxt;
  logic         w_capture;
  logic         r_rx_clear;
  logic         r_overrun;
  logic         w_full;
  logic         w_empty;
  logic [7:0]   w_head;
  logic [AW:0]  w_count;
  logic         w_pop_ok;
  logic         w_drop;
  logic [15:0]  w_out;
  logic         w_unused_bits;

  assign w_unused_bits = ^bus.rx_word[14:8];

  uart_byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_capture),
    .i_data  (bus.rx_word[7:0]),
    .i_pop   (bus.load),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Receiver output is ignored for two cycles
  // after capture while its clear takes effect.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!bus.rx_word[EMPTY_BIT]) begin
          w_capture   = 1'b1;
          w_state_nxt = ACK;
        end
      end
      ACK:     w_state_nxt = SETTLE;
      SETTLE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_pop_ok = bus.load & ~w_empty;
  assign w_drop   = w_capture & w_full &
    ~bus.load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rx_clear <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rx_clear <= w_capture;
      if (w_drop)
        r_overrun <= 1'b1;
      else if (w_pop_ok)
        r_overrun <= 1'b0;
    end
  end

  always_comb begin
    w_out = w_empty ? EMPTY_WORD : 16'h0000;
    w_out[OVERRUN_BIT] = r_overrun;
    w_out[7:0] = w_empty ? 8'h00 : w_head;
  end

  assign bus.out      = w_out;
  assign bus.count    = w_count;
  assign bus.rx_clear = r_rx_clear;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with
// immediate assertions at each check.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  uart_rx_fifo_if #(.DEPTH(16)) bus ();

  uart_rx_fifo #(
    .DEPTH(16)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.rx_word = {8'h00, b};
    tick();
    bus.rx_word = 16'h8000;
    tick();
    tick();
  endtask

  task automatic pop_one();
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_b;
    bus.rx_word = 16'h8000;
    bus.load = 1'b0;
    #2;
    check("rst_out", 32'(bus.out), 32'h8000);
    check("rst_cnt", 32'(bus.count), 32'd0);
    check("rst_clr", 32'(bus.rx_clear), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // single byte
    bus.rx_word = 16'h0041;
    tick();
    check("sb_clr1", 32'(bus.rx_clear), 32'd1);
    check("sb_out", 32'(bus.out), 32'h0041);
    check("sb_cnt", 32'(bus.count), 32'd1);
    bus.rx_word = 16'h8000;
    tick();
    check("sb_clr0", 32'(bus.rx_clear), 32'd0);
    tick();
    pop_one();
    check("sb_pop_out", 32'(bus.out), 32'h8000);
    check("sb_pop_cnt", 32'(bus.count), 32'd0);

    // held word: captured once only
    bus.rx_word = 16'h0055;
    tick();
    check("hw_clr1", 32'(bus.rx_clear), 32'd1);
    tick();
    check("hw_clr2", 32'(bus.rx_clear), 32'd0);
    tick();
    check("hw_clr3", 32'(bus.rx_clear), 32'd0);
    bus.rx_word = 16'h8000;
    tick();
    check("hw_clr4", 32'(bus.rx_clear), 32'd0);
    check("hw_cnt", 32'(bus.count), 32'd1);
    check("hw_out", 32'(bus.out), 32'h0055);
    pop_one();
    check("hw_pop_cnt", 32'(bus.count), 32'd0);

    // fill and overflow
    for (int i = 0; i < 16; i++)
      push_byte(8'(i));
    check("fill_cnt", 32'(bus.count), 32'd16);
    check("fill_out", 32'(bus.out), 32'h0000);
    bus.rx_word = 16'h0010;
    tick();
    check("ovf_clr", 32'(bus.rx_clear), 32'd1);
    check("ovf_cnt", 32'(bus.count), 32'd16);
    check("ovf_out", 32'(bus.out), 32'h4000);
    bus.rx_word = 16'h8000;
    tick();
    tick();
    pop_one();
    check("ovf_pop_out", 32'(bus.out), 32'h0001);
    check("ovf_pop_cnt", 32'(bus.count), 32'd15);

    // push and pop together while full
    push_byte(8'h10);
    check("pp_pre_cnt", 32'(bus.count), 32'd16);
    bus.rx_word = 16'h0077;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    bus.rx_word = 16'h8000;
    check("pp_cnt", 32'(bus.count), 32'd16);
    check("pp_out", 32'(bus.out), 32'h0002);
    tick();
    tick();
    for (int i = 0; i < 16; i++) begin
      exp_b = (i < 15) ? 8'(i + 2) : 8'h77;
      check("drain", 32'(bus.out), 32'(exp_b));
      pop_one();
    end
    check("drain_out", 32'(bus.out), 32'h8000);
    check("drain_cnt", 32'(bus.count), 32'd0);

    // pop when empty
    bus.load = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("pe_out", 32'(bus.out), 32'h8000);
      check("pe_cnt", 32'(bus.count), 32'd0);
    end
    bus.load = 1'b0;
    push_byte(8'h5A);
    check("pe_push", 32'(bus.out), 32'h005A);
    check("pe_cnt1", 32'(bus.count), 32'd1);

    // async reset while in ACK with count 3
    push_byte(8'h61);
    bus.rx_word = 16'h0062;
    tick();
    check("ar_cnt3", 32'(bus.count), 32'd3);
    check("ar_clr1", 32'(bus.rx_clear), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("ar_clr0", 32'(bus.rx_clear), 32'd0);
    check("ar_out", 32'(bus.out), 32'h8000);
    check("ar_cnt0", 32'(bus.count), 32'd0);
    #1 reset = 1'b0;
    tick();
    check("ar_cap_clr", 32'(bus.rx_clear), 32'd1);
    check("ar_cap_out", 32'(bus.out), 32'h0062);
    check("ar_cap_cnt", 32'(bus.count), 32'd1);
    bus.rx_word = 16'h8000;
    tick();
    tick();
    push_byte(8'h63);
    check("ar_cnt2", 32'(bus.count), 32'd2);
    check("ar_head", 32'(bus.out), 32'h0062);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
